ysyx_24090012_lsu_ext: RTL and testbench

YSYX_24090012_LSU_EXT -- requirements
Module: ysyx_24090012_lsu_ext

---
 rtl/ysyx_24090012_lsu_ext.sv | 166 ++++++++++++++++
 tb/tb_ysyx_24090012_lsu_ext.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_lsu_ext.sv
// Load/store unit bridging one EXU request at a time onto a word-wide SRAM port.
// Handles byte/half/word lane steering, load extension, alignment errors and an SRAM timeout.
module ysyx_24090012_lsu_ext #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_valid,
  input  logic              sram_ready,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_wmask,
  output logic              sram_wen
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic               wen_q, wen_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [1:0]         off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_legal = 1'b1;
      2'd1:    is_legal = ~off[0];
      2'd2:    is_legal = (off == 2'd0);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          off_d   = req_addr[1:0];
          rdata_d = 32'd0;
          if (is_legal(req_size, req_addr[1:0])) begin
            state_d = REQ;
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            wmask_d = req_wen ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
            wen_d   = req_wen;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            // Misaligned or illegal size never touches the SRAM.
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (sram_ready) begin
          state_d = RESP;
          rdata_d = wen_q ? 32'd0 : load_extract(sram_rdata, size_q, off_q, sgn_q);
          err_d   = 1'b0;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobes are qualified by state so a stale store never leaks outside REQ.
  assign req_ready  = (state_q == IDLE) & ~rst;
  assign sram_valid = (state_q == REQ);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_wmask = (state_q == REQ) ? wmask_q : 4'b0000;
  assign sram_wen   = (state_q == REQ) & wen_q;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24090012_lsu_ext.sv
// Scoreboard bench for the LSU: the driver queues expected responses, a monitor checks them on handshake.
module tb_ysyx_24090012_lsu_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] sram_addr;
  logic        sram_valid;
  logic        sram_ready;
  logic [31:0] sram_rdata;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic        sram_wen;

  int passed = 0;
  int total  = 0;
  logic [32:0] exp_q[$];

  ysyx_24090012_lsu_ext #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_addr(sram_addr), .sram_valid(sram_valid), .sram_ready(sram_ready),
    .sram_rdata(sram_rdata), .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_wen(sram_wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every accepted response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  // dly: REQ cycle index carrying sram_ready (-1 = never); exp_sv: expected sram_valid cycles.
  task automatic txn(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] wd, input logic [31:0] rd, input int dly, input int rr_dly,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_sv,
                     input logic [31:0] exp_sa, input logic [31:0] exp_sw, input logic [3:0] exp_wm);
    int k;
    int sv_cnt;
    logic seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz; req_signed = sg; req_wdata = wd;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; sv_cnt = 0; seen = 1'b0;
    while (!seen && k < 64) begin
      sram_ready = (dly >= 0) && (k == dly);
      sram_rdata = rd;
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        if (sram_valid) begin
          sv_cnt++;
          if (sv_cnt == 1) begin
            chk("sram_addr", sram_addr, exp_sa);
            chk("sram_wdata", sram_wdata, exp_sw);
            chk("sram_wmask", {28'd0, sram_wmask}, {28'd0, exp_wm});
            chk("sram_wen", {31'd0, sram_wen}, {31'd0, w});
          end
        end
        @(posedge clk); #1;
        k++;
      end
    end
    sram_ready = 1'b0;
    chk("resp_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    chk("sram_valid_cycles", sv_cnt, exp_sv);
    chk("sram_valid_in_resp", {31'd0, sram_valid}, 32'd0);
    chk("latency", k + 1, (exp_sv == 0) ? 1 : ((dly >= 0) ? dly + 2 : exp_sv + 1));
    for (int i = 0; i < rr_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", {31'd0, resp_err}, {31'd0, exp_err});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {31'd0, req_ready}, 32'd1);
    chk("resp_dropped", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0; sram_ready = 1'b0; sram_rdata = '0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_sram_valid", {31'd0, sram_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_sram_wen", {31'd0, sram_wen}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // sram_ready in IDLE must be ignored.
    @(posedge clk); #1; sram_ready = 1'b1;
    @(posedge clk); #1; sram_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_ignored", {30'd0, resp_valid, sram_valid}, 32'd0);

    //  addr         w     sz    sg    wdata         srdata        dly rr  exp_rd        err  sv sram_addr     sram_wdata    wmask
    txn(32'h100, 1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 1, 32'h100, 32'h0,        4'b0000);
    txn(32'h103, 1'b0, 2'd0, 1'b1, 32'h0,        32'h80123456, 0, 0, 32'hFFFFFF80, 1'b0, 1, 32'h100, 32'h0,        4'b0000);
    txn(32'h103, 1'b0, 2'd0, 1'b0, 32'h0,        32'h80123456, 1, 0, 32'h00000080, 1'b0, 2, 32'h100, 32'h0,        4'b0000);
    txn(32'h202, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h0,        2, 1, 32'h0,        1'b0, 3, 32'h200, 32'hABCD0000, 4'b1100);
    txn(32'h101, 1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        1'b1, 0, 32'h0,   32'h0,        4'b0000);
    txn(32'h300, 1'b0, 2'd2, 1'b0, 32'h0,        32'h11111111, -1, 3, 32'h0,       1'b1, 4, 32'h300, 32'h0,        4'b0000);
    txn(32'h302, 1'b0, 2'd1, 1'b1, 32'h0,        32'h80011234, 3, 0, 32'hFFFF8001, 1'b0, 4, 32'h300, 32'h0,        4'b0000);
    txn(32'h401, 1'b1, 2'd0, 1'b0, 32'h000000A5, 32'h0,        0, 0, 32'h0,        1'b0, 1, 32'h400, 32'h0000A500, 4'b0010);
    txn(32'h500, 1'b1, 2'd2, 1'b0, 32'h12345678, 32'h0,        0, 0, 32'h0,        1'b0, 1, 32'h500, 32'h12345678, 4'b1111);
    txn(32'h600, 1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        1'b1, 0, 32'h0,   32'h0,        4'b0000);
    txn(32'h601, 1'b1, 2'd1, 1'b0, 32'h0000FFFF, 32'h0,        0, 0, 32'h0,        1'b1, 0, 32'h0,   32'h0,        4'b0000);

    // Reset while the SRAM access is outstanding: no response may follow.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h700; req_wen = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_sram_valid", {31'd0, sram_valid}, 32'd1);
    #1; rst = 1'b1;
    #1;
    chk("mid_rst_sram_valid", {31'd0, sram_valid}, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("after_rst_resp_valid", {31'd0, resp_valid}, 32'd0);

    txn(32'h702, 1'b0, 2'd1, 1'b0, 32'h0,        32'hBEEF0000, 0, 0, 32'h0000BEEF, 1'b0, 1, 32'h700, 32'h0,        4'b0000);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
